// File: rtl/mem_port_arbiter.sv
// Shared-memory arbiter between the fetch stage and the memory stage.
// One single-port memory serves both instruction fetches and data loads and
// stores. A three-state FSM serialises the accesses, picks a winner on ties,
// discards fetches killed by a redirect and raises the data-side stall.

package mem_port_arbiter_pkg;
  // Encoding of the read/write select on the data port and the memory port.
  localparam logic RD = 1'b0;
  // Instruction presented on the fetch port before the first fetch completes.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// Handshake on both processor ports: the stage raises x_req_i and keeps the
// address (and store data) stable until it sees x_ready_o. x_ready_o is a
// single-cycle pulse that marks completion and qualifies the read data. A port
// whose ready is high in a cycle is not eligible for a new grant in that cycle,
// which keeps a held request from being served twice. On the memory side
// mem_req_o is a single-cycle pulse. The address, read/write select and write
// data stay stable until the single-cycle mem_rsp_valid_i strobe arrives.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter bit          PRIO_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  // fetch port
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_req_i,
  input  logic              if_kill_i,
  output logic [DATA_W-1:0] if_rd_instr_o,
  output logic              if_ready_o,
  // data port
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic              dm_rd_wr_i,
  input  logic [DATA_W-1:0] dm_wr_data_i,
  input  logic              dm_req_i,
  output logic [DATA_W-1:0] dm_rd_data_o,
  output logic              dm_ready_o,
  output logic              stall_proc_o,
  // memory port
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_wr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  input  logic              mem_rsp_valid_i,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  // FSM state for observation: 0 idle, 1 fetch in flight, 2 data in flight
  output logic [1:0]        state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  state_t              state_q,       state_d;
  logic                last_grant_q,  last_grant_d;
  logic                kill_pend_q,   kill_pend_d;
  logic                if_ready_q,    if_ready_d;
  logic                dm_ready_q,    dm_ready_d;
  logic [DATA_W-1:0]   if_rd_instr_q, if_rd_instr_d;
  logic [DATA_W-1:0]   dm_rd_data_q,  dm_rd_data_d;
  logic                mem_req_q,     mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q,    mem_addr_d;
  logic                mem_rd_wr_q,   mem_rd_wr_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;

  logic                if_elig;
  logic                dm_elig;
  logic                grant_if;
  logic                grant_dm;
  logic                fetch_killed;

  // Eligibility and tie-break between the two ports (only acted on in IDLE).
  // A fetch that is being killed in this very cycle is never started, so a
  // kill in the would-be grant cycle simply suppresses the grant.
  always_comb begin
    if_elig  = if_req_i & ~if_ready_q & ~if_kill_i;
    dm_elig  = dm_req_i & ~dm_ready_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (if_elig && dm_elig) begin
      if (PRIO_DATA || (last_grant_q == GRANT_IF)) begin
        grant_dm = 1'b1;
      end else begin
        grant_if = 1'b1;
      end
    end else begin
      grant_if = if_elig;
      grant_dm = dm_elig;
    end
  end

  // A fetch is discarded if a kill was seen earlier in the transaction or
  // arrives together with the memory response.
  assign fetch_killed = kill_pend_q | if_kill_i;

  // Next-state and datapath update for the arbitration FSM.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    kill_pend_d   = kill_pend_q;
    if_ready_d    = 1'b0;
    dm_ready_d    = 1'b0;
    if_rd_instr_d = if_rd_instr_q;
    dm_rd_data_d  = dm_rd_data_q;
    mem_req_d     = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_rd_wr_d   = mem_rd_wr_q;
    mem_wr_data_d = mem_wr_data_q;

    unique case (state_q)
      IDLE: begin
        // Stray responses are ignored here; nothing depends on mem_rsp_valid_i.
        kill_pend_d = 1'b0;
        if (grant_dm) begin
          state_d       = BUSY_DM;
          mem_req_d     = 1'b1;
          mem_addr_d    = dm_addr_i;
          mem_rd_wr_d   = dm_rd_wr_i;
          mem_wr_data_d = dm_wr_data_i;
        end else if (grant_if) begin
          // Fetches are always reads; the write data register keeps its value.
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_addr_d  = if_addr_i;
          mem_rd_wr_d = RD;
        end
      end

      BUSY_IF: begin
        if (if_kill_i) begin
          kill_pend_d = 1'b1;
        end
        if (mem_rsp_valid_i) begin
          state_d      = IDLE;
          last_grant_d = GRANT_IF;
          kill_pend_d  = 1'b0;
          if (!fetch_killed) begin
            if_ready_d    = 1'b1;
            if_rd_instr_d = mem_rd_data_i;
          end
        end
      end

      BUSY_DM: begin
        // Redirects only concern the fetch side; if_kill_i is ignored here.
        if (mem_rsp_valid_i) begin
          state_d      = IDLE;
          last_grant_d = GRANT_DM;
          dm_ready_d   = 1'b1;
          if (mem_rd_wr_q == RD) begin
            dm_rd_data_d = mem_rd_data_i;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_IF;
      kill_pend_q   <= 1'b0;
      if_ready_q    <= 1'b0;
      dm_ready_q    <= 1'b0;
      if_rd_instr_q <= DATA_W'(NOP_INSTR);
      dm_rd_data_q  <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_rd_wr_q   <= RD;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      kill_pend_q   <= kill_pend_d;
      if_ready_q    <= if_ready_d;
      dm_ready_q    <= dm_ready_d;
      if_rd_instr_q <= if_rd_instr_d;
      dm_rd_data_q  <= dm_rd_data_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign if_rd_instr_o = if_rd_instr_q;
  assign if_ready_o    = if_ready_q;
  assign dm_rd_data_o  = dm_rd_data_q;
  assign dm_ready_o    = dm_ready_q;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_rd_wr_o   = mem_rd_wr_q;
  assign mem_wr_data_o = mem_wr_data_q;
  assign state_dbg_o   = state_q;

  // The data stage is held until its access completes.
  assign stall_proc_o  = dm_req_i & ~dm_ready_q;

endmodule
